// File: rtl/adder_seq_pkg.sv
// adder_seq_pkg: shared types for the byte-serial add/sub/accumulate engine.
//   mode_e  : transaction opcode, sampled on the first input beat
//   state_e : engine FSM states
//   FLAG_*  : bit positions inside out_flags {N, Z, V, C}
package adder_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'b00,
        MODE_SUB = 2'b01,
        MODE_ACC = 2'b10,
        MODE_CLR = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_OUT
    } state_e;

    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational W-bit adder slice, time-multiplexed by the engine.
//   a, b   : operand slices
//   inv_b  : invert b (subtract when combined with cin=1 on slice 0)
//   cin    : carry into bit 0
//   sum    : slice result
//   cout   : carry out of the MSB
//   c_msb  : carry into the MSB (cout ^ c_msb gives signed overflow)
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         inv_b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [W-1:0] bx;
    logic [W:0]   full;

    assign bx    = inv_b ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, cin};
    assign sum   = full[W-1:0];
    assign cout  = full[W];
    // Carry into the MSB recovered from the MSB sum bit; avoids slicing a[W-2:0]
    // so the module also works for W=1.
    assign c_msb = full[W-1] ^ a[W-1] ^ bx[W-1];

endmodule

// File: rtl/adder_seq_engine.sv
// adder_seq_engine: byte-serial add / subtract / accumulate engine.
// Operands arrive as little-endian BUS_W-bit beats over a valid/ready bus,
// are summed one slice per cycle through a single adder_slice with a
// registered carry, and the result plus flags leave over a second
// valid/ready bus, again little-endian.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake
//   in_data             operand slice
//   in_mode             00 ADD, 01 SUB, 10 ACC, 11 CLR (first beat only)
//   out_valid/out_ready result beat handshake
//   out_data            result slice
//   out_flags           {negative, zero, overflow, carry}, constant per result
//   busy                high whenever the FSM is not idle
//
// Build option: define ADDER_SEQ_SATURATE_EN to clamp signed overflow to the
// most positive / most negative value (accumulator stores the clamped value).
import adder_seq_pkg::*;

module adder_seq_engine #(
    parameter int WIDTH = 16,
    parameter int BUS_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BUS_W-1:0] out_data,
    output logic [3:0]       out_flags,
    output logic             busy
);

    localparam int N  = WIDTH / BUS_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e          state, state_n;
    mode_e           mode_q, first_mode;
    logic [CW-1:0]   cnt, cnt_n;
    logic            cnt_last;
    logic [WIDTH-1:0] a_reg, b_reg, acc_reg, res_reg;
    logic [WIDTH-1:0] res_full, res_final;
    logic            carry_q;
    logic            in_fire, out_fire;
    int              idx, nidx;

    logic [BUS_W-1:0] sl_a, sl_b, sl_sum;
    logic             sl_inv, sl_cin, sl_cout, sl_cmsb;
    logic             v_raw;
    logic [3:0]       flags_n;

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign first_mode = mode_e'(in_mode);
    assign cnt_last   = (cnt == LAST);
    assign idx        = int'(cnt) * BUS_W;
    assign nidx       = int'(cnt_n) * BUS_W;

    // ---------------- next-state / beat counter ----------------
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                // A non-CLR first beat is slice 0 of the first operand.
                if (in_fire && first_mode != MODE_CLR) begin
                    if (cnt_last) begin
                        cnt_n   = '0;
                        state_n = (first_mode == MODE_ACC) ? S_EXEC : S_LOAD_B;
                    end else begin
                        cnt_n   = cnt + 1'b1;
                        state_n = S_LOAD_A;
                    end
                end
            end
            S_LOAD_A: begin
                if (in_fire) begin
                    if (cnt_last) begin
                        cnt_n   = '0;
                        state_n = (mode_q == MODE_ACC) ? S_EXEC : S_LOAD_B;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_LOAD_B: begin
                if (in_fire) begin
                    if (cnt_last) begin
                        cnt_n   = '0;
                        state_n = S_EXEC;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_last) begin
                    cnt_n   = '0;
                    state_n = S_OUT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_OUT: begin
                if (out_fire) begin
                    if (cnt_last) begin
                        cnt_n   = '0;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // ---------------- slice datapath ----------------
    // ACC adds the received operand (held in a_reg) onto the accumulator.
    always_comb begin
        sl_a   = (mode_q == MODE_ACC) ? acc_reg[idx +: BUS_W] : a_reg[idx +: BUS_W];
        sl_b   = (mode_q == MODE_ACC) ? a_reg[idx +: BUS_W]   : b_reg[idx +: BUS_W];
        sl_inv = (mode_q == MODE_SUB);
        sl_cin = (cnt == '0) ? (mode_q == MODE_SUB) : carry_q;
    end

    adder_slice #(.W(BUS_W)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .inv_b (sl_inv),
        .cin   (sl_cin),
        .sum   (sl_sum),
        .cout  (sl_cout),
        .c_msb (sl_cmsb)
    );

    assign v_raw = sl_cout ^ sl_cmsb;

    always_comb begin
        res_full = res_reg;
        res_full[idx +: BUS_W] = sl_sum;
    end

`ifdef ADDER_SEQ_SATURATE_EN
    // A wrapped negative MSB means the true result was too positive.
    always_comb begin
        res_final = res_full;
        if (v_raw && mode_q != MODE_CLR)
            res_final = res_full[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                          : {1'b1, {(WIDTH-1){1'b0}}};
    end
`else
    assign res_final = res_full;
`endif

    // Only meaningful on the last EXEC slice; carry becomes borrow for SUB.
    always_comb begin
        flags_n         = '0;
        flags_n[FLAG_C] = (mode_q == MODE_SUB) ? ~sl_cout : sl_cout;
        flags_n[FLAG_V] = v_raw;
        flags_n[FLAG_Z] = (res_final == '0);
        flags_n[FLAG_N] = res_final[WIDTH-1];
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mode_q    <= MODE_ADD;
            a_reg     <= '0;
            b_reg     <= '0;
            acc_reg   <= '0;
            res_reg   <= '0;
            carry_q   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_flags <= '0;
            busy      <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            in_ready <= (state_n == S_IDLE) || (state_n == S_LOAD_A) || (state_n == S_LOAD_B);
            busy     <= (state_n != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (in_fire) begin
                        mode_q <= first_mode;
                        if (first_mode == MODE_CLR)
                            acc_reg <= '0;
                        else
                            a_reg[idx +: BUS_W] <= in_data;
                    end
                end
                S_LOAD_A: if (in_fire) a_reg[idx +: BUS_W] <= in_data;
                S_LOAD_B: if (in_fire) b_reg[idx +: BUS_W] <= in_data;
                S_EXEC: begin
                    carry_q <= sl_cout;
                    if (cnt_last) begin
                        res_reg   <= res_final;
                        out_data  <= res_final[BUS_W-1:0];
                        out_flags <= flags_n;
                        out_valid <= 1'b1;
                        if (mode_q == MODE_ACC)
                            acc_reg <= res_final;
                    end else begin
                        res_reg <= res_full;
                    end
                end
                S_OUT: begin
                    if (out_fire) begin
                        if (cnt_last)
                            out_valid <= 1'b0;
                        else
                            out_data <= res_reg[nidx +: BUS_W];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_seq_engine.sv
// tb_adder_seq_engine: directed self-checking bench for adder_seq_engine
// (WIDTH=16, BUS_W=8). Inputs change and outputs are sampled on the falling
// edge so every handshake is decided cleanly at the next rising edge.
module tb_adder_seq_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [1:0] in_mode = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [3:0] out_flags;
    logic       busy;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] M_ADD = 2'b00, M_SUB = 2'b01, M_ACC = 2'b10, M_CLR = 2'b11;

    adder_seq_engine #(.WIDTH(16), .BUS_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive one input beat from a falling edge; returns at the falling edge
    // after the rising edge that transferred it.
    task automatic send_beat(input logic [7:0] d, input logic [1:0] m);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv_beat(output logic [7:0] d, output logic [3:0] f);
        int guard = 0;
        out_ready = 1'b1;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (!out_valid) begin
            bad++;
            $display("FAIL recv_timeout: out_valid=%b want 1", out_valid);
        end
        d = out_data;
        f = out_flags;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic [3:0] f0, output logic [3:0] f1);
        send_beat(a[7:0], m);
        send_beat(a[15:8], m);
        if (m != M_ACC) begin
            send_beat(b[7:0], m);
            send_beat(b[15:8], m);
        end
        recv_beat(r[7:0], f0);
        recv_beat(r[15:8], f1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total += 5;
        if (in_ready !== 1'b1)    begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0)   begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (out_data !== 8'h00)   begin bad++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        if (out_flags !== 4'h0)   begin bad++; $display("FAIL reset_out_flags: got %b want 0000", out_flags); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_latency;
        logic [7:0] d0, d1;
        logic [3:0] f0, f1;
        send_beat(8'hFF, M_ADD);
        send_beat(8'h00, M_ADD);
        send_beat(8'h01, M_ADD);
        send_beat(8'h00, M_ADD);
        // One edge after the last transfer: still computing.
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL add_lat_e1: out_valid=%b want 0", out_valid); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL add_lat_e2: out_valid=%b want 0", out_valid); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL add_lat_e3: out_valid=%b want 1", out_valid); end
        recv_beat(d0, f0);
        recv_beat(d1, f1);
        total += 4;
        if (d0 !== 8'h00) begin bad++; $display("FAIL add_beat0: got %h want 00", d0); end
        if (d1 !== 8'h01) begin bad++; $display("FAIL add_beat1: got %h want 01", d1); end
        if (f0 !== 4'b0000) begin bad++; $display("FAIL add_flags: got %b want 0000", f0); end
        if (f1 !== 4'b0000) begin bad++; $display("FAIL add_flags_beat1: got %b want 0000", f1); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL add_valid_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_sub;
        logic [15:0] r;
        logic [3:0]  f0, f1;
        run_op(M_SUB, 16'h0000, 16'h0001, r, f0, f1);
        total += 3;
        if (r !== 16'hFFFF)  begin bad++; $display("FAIL sub_borrow_res: got %h want ffff", r); end
        if (f0 !== 4'b1001)  begin bad++; $display("FAIL sub_borrow_flags: got %b want 1001", f0); end
        if (f1 !== 4'b1001)  begin bad++; $display("FAIL sub_borrow_flags_b1: got %b want 1001", f1); end
        run_op(M_SUB, 16'h1234, 16'h1234, r, f0, f1);
        total += 2;
        if (r !== 16'h0000)  begin bad++; $display("FAIL sub_zero_res: got %h want 0000", r); end
        if (f0 !== 4'b0100)  begin bad++; $display("FAIL sub_zero_flags: got %b want 0100", f0); end
    endtask

    task automatic test_overflow;
        logic [15:0] r;
        logic [3:0]  f0, f1;
        run_op(M_ADD, 16'h7FFF, 16'h0001, r, f0, f1);
        total += 2;
`ifdef ADDER_SEQ_SATURATE_EN
        if (r !== 16'h7FFF)  begin bad++; $display("FAIL ovf_res: got %h want 7fff", r); end
        if (f0 !== 4'b0010)  begin bad++; $display("FAIL ovf_flags: got %b want 0010", f0); end
`else
        if (r !== 16'h8000)  begin bad++; $display("FAIL ovf_res: got %h want 8000", r); end
        if (f0 !== 4'b1010)  begin bad++; $display("FAIL ovf_flags: got %b want 1010", f0); end
`endif
    endtask

    task automatic test_acc;
        logic [15:0] r;
        logic [3:0]  f0, f1;
        logic [15:0] exp_r [3] = '{16'h0010, 16'h0020, 16'h0030};
        send_beat(8'hAB, M_CLR);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL clr_no_output: busy=%b out_valid=%b want 0 0", busy, out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            run_op(M_ACC, 16'h0010, 16'h0000, r, f0, f1);
            total += 2;
            if (r !== exp_r[i]) begin bad++; $display("FAIL acc_step%0d: got %h want %h", i, r, exp_r[i]); end
            if (f0 !== 4'b0000) begin bad++; $display("FAIL acc_step%0d_flags: got %b want 0000", i, f0); end
        end
        run_op(M_ACC, 16'hFFE0, 16'h0000, r, f0, f1);
        total += 2;
        if (r !== 16'h0010)  begin bad++; $display("FAIL acc_wrap_res: got %h want 0010", r); end
        if (f0 !== 4'b0001)  begin bad++; $display("FAIL acc_wrap_flags: got %b want 0001", f0); end
    endtask

    task automatic test_backpressure;
        logic [7:0] d0, d1;
        logic [3:0] f0, f1;
        int guard = 0;
        send_beat(8'h02, M_ADD);
        send_beat(8'h01, M_ADD);
        send_beat(8'h04, M_ADD);
        send_beat(8'h03, M_ADD);
        while (!out_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 3; i++) begin
            total += 5;
            if (out_data !== 8'h06)  begin bad++; $display("FAIL bp_data_c%0d: got %h want 06", i, out_data); end
            if (out_flags !== 4'h0)  begin bad++; $display("FAIL bp_flags_c%0d: got %b want 0000", i, out_flags); end
            if (out_valid !== 1'b1)  begin bad++; $display("FAIL bp_valid_c%0d: got %b want 1", i, out_valid); end
            if (in_ready !== 1'b0)   begin bad++; $display("FAIL bp_in_ready_c%0d: got %b want 0", i, in_ready); end
            if (busy !== 1'b1)       begin bad++; $display("FAIL bp_busy_c%0d: got %b want 1", i, busy); end
            @(negedge clk);
        end
        recv_beat(d0, f0);
        recv_beat(d1, f1);
        total += 2;
        if (d0 !== 8'h06) begin bad++; $display("FAIL bp_beat0: got %h want 06", d0); end
        if (d1 !== 8'h04) begin bad++; $display("FAIL bp_beat1: got %h want 04", d1); end
    endtask

    task automatic test_rst_mid;
        logic [15:0] r;
        logic [3:0]  f0, f1;
        send_beat(8'h11, M_ADD);
        send_beat(8'h22, M_ADD);
        send_beat(8'h33, M_ADD);
        // Now in LOAD_B with one slice of B held; offer another beat during reset.
        in_valid = 1'b1;
        in_data  = 8'h44;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        total += 3;
        if (in_ready !== 1'b1)  begin bad++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        if (busy !== 1'b0)      begin bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        run_op(M_ACC, 16'h0005, 16'h0000, r, f0, f1);
        total += 2;
        if (r !== 16'h0005)  begin bad++; $display("FAIL rst_acc_res: got %h want 0005", r); end
        if (f0 !== 4'b0000)  begin bad++; $display("FAIL rst_acc_flags: got %b want 0000", f0); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add_latency();
        test_sub();
        test_overflow();
        test_acc();
        test_backpressure();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adder_seq_engine.md
Name: adder_seq_engine

Overview:
- Parametrised, byte-serial add/subtract/accumulate engine; next generation of the team's combinational 8-in/8-out adder top.
- Operands arrive over a narrow valid/ready bus in BUS_W-bit beats and are summed one slice per cycle with a registered carry.
- The result and flags return over a second valid/ready bus.
- Sits directly behind the 8-bit pin wrapper, so wide arithmetic fits an 8-bit I/O budget.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of BUS_W and at least BUS_W.
- BUS_W, 8, width of the input and output data buses.
- Derived: N = WIDTH/BUS_W beats per operand.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts an input beat this cycle.
- in_data  in  BUS_W  operand slice, little-endian (slice 0 first).
- in_mode  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR; sampled only on the first beat of a transaction.
- out_valid  out  1  result beat valid.
- out_ready  in  1  sink accepts a result beat.
- out_data  out  BUS_W  result slice, little-endian.
- out_flags  out  4  {negative, zero, overflow, carry}; constant across all beats of one result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- A beat transfers when valid && ready. All outputs are registered.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_flags=0, busy=0, accumulator=0, beat counter=0.
- IDLE: in_ready=1. The first transfer latches the mode.
  - ADD/SUB: store slice 0 of A, go to LOAD_A (or to LOAD_B when N=1).
  - ACC: store slice 0 of the operand, go to LOAD_A (or EXEC when N=1).
  - CLR: accumulator:=0, data ignored, stay in IDLE; produces no output.
- LOAD_A: accept beats until N slices of A are held, then go to LOAD_B (ADD/SUB) or EXEC (ACC).
- LOAD_B: accept N slices of B, then go to EXEC. in_ready=1 in LOAD_A/LOAD_B only.
- EXEC: one slice per cycle, N cycles, carry registered between slices.
  - ADD: A+B, carry_in=0.
  - SUB: A+~B, carry_in=1.
  - ACC: acc+A; the accumulator updates at the end of EXEC.
  - After the last slice: compute flags, load output register, go to OUT.
- OUT: out_valid=1, driving slice k. Advance k only on a transfer.
  - out_data is held stable while out_ready=0.
  - After slice N-1 transfers, go to IDLE; out_valid drops the next cycle.
- Latency: the last input transfer is followed by N EXEC cycles; the first result beat is valid in the next cycle.
- Flags:
  - carry: unsigned carry-out (ADD/ACC) or borrow (SUB, 1 when A<B unsigned).
  - overflow: signed two's-complement overflow.
  - zero: full WIDTH result is 0.
  - negative: result MSB.
- Wrap-around: without saturation, results are modulo 2^WIDTH. The accumulator wraps silently; its carry is reported in the flags.
- No overlap: a new transaction is not accepted until the last result beat transfers. in_valid is ignored while in_ready=0.
- rst asserted in any state (including mid-LOAD or mid-OUT):
  - The partial transaction is discarded and the accumulator clears.
  - The next cycle shows reset values.
  - rst takes priority over a simultaneous transfer.
- in_mode on non-first beats is ignored.

Optional Feature:
- Macro: ADDER_SEQ_SATURATE_EN.
- Defined: for ADD/SUB/ACC with signed overflow, the result is clamped to 0111..1 (positive overflow) or 1000..0 (negative overflow). The clamp is applied at the EXEC->OUT transition; in ACC mode the accumulator also stores the clamped value.
  - overflow=1 is still reported.
  - negative/zero reflect the clamped value.
  - carry is unchanged.
- Undefined: wrapping arithmetic only; no clamp logic is synthesised.

Decomposition:
- Package adder_seq_pkg holds:
  - mode enum (ADD/SUB/ACC/CLR) and state enum (IDLE/LOAD_A/LOAD_B/EXEC/OUT).
  - flag bit indices: FLAG_C=0, FLAG_V=1, FLAG_Z=2, FLAG_N=3.
- One sub-module: adder_slice, a combinational BUS_W-bit add with invert-B, carry in/out and MSB carry-in for overflow, instantiated once and time-multiplexed.
- FSM, counters and the WIDTH-bit registers stay in adder_seq_engine.

Test Plan (WIDTH=16, BUS_W=8):
- ADD, beats FF,00 then 01,00 -> out 00,01 (0x0100); flags C=0 V=0 Z=0 N=0; first out_valid exactly 2 cycles after the last input transfer.
- SUB 0x0000-0x0001 -> out FF,FF; C=1 (borrow), N=1, V=0, Z=0. SUB 0x1234-0x1234 -> 00,00, Z=1, C=0.
- ADD 0x7FFF+0x0001 -> 00,80, V=1, N=1. With ADDER_SEQ_SATURATE_EN -> FF,7F, V=1, N=0.
- CLR, then ACC 0x0010 three times -> results 0x0010, 0x0020, 0x0030; ACC 0xFFE0 next -> 0x0010, C=1.
- Hold out_ready=0 for 3 cycles on result beat 0 -> out_data/out_flags stable, out_valid=1, in_ready=0, busy=1; resumes correctly when released.
- Assert rst for 1 cycle mid-LOAD_B -> next cycle in_ready=1, out_valid=0, busy=0; a following ACC 0x0005 returns 0x0005 (accumulator cleared).
